// File: rtl/pc_sequencer.sv
// Program-counter sequencer driving a return-address stack (NEXT/JUMP/CALL/RET).
// Optional macro PC_SEQ_TRAP_EN: stack faults load TRAP_VECTOR instead of PC+1.
module pc_sequencer #(
    parameter int unsigned     AW           = 8,
    parameter logic [AW-1:0]   RESET_VECTOR = '0,
    parameter logic [AW-1:0]   TRAP_VECTOR  = 8'hF0
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          OP_VALID,
    input  logic [1:0]    OP,
    input  logic [AW-1:0] TARGET,
    input  logic          FAULT_CLR,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic [1:0]    FAULT,
    output logic          STK_CE,
    output logic          STK_NRW,
    output logic [AW-1:0] STK_DIN,
    input  logic [AW-1:0] STK_DOUT,
    input  logic          STK_FULL,
    input  logic          STK_EMPTY
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, LOAD} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] tgt_q, tgt_d;
    logic [AW-1:0] din_q, din_d;
    logic [1:0]    fault_q, fault_d;
    logic          ce_q, ce_d;
    logic          nrw_q, nrw_d;
    logic          busy_q, busy_d;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] fault_pc;

    assign pc_inc = pc_q + AW'(1);

`ifdef PC_SEQ_TRAP_EN
    assign fault_pc = TRAP_VECTOR;
`else
    logic unused_trap;
    assign unused_trap = ^TRAP_VECTOR;
    assign fault_pc    = pc_inc;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        din_d   = din_q;
        ce_d    = 1'b0;
        nrw_d   = nrw_q;
        // Clear first so a fault raised this cycle overrides FAULT_CLR.
        fault_d = FAULT_CLR ? 2'b00 : fault_q;
        case (state_q)
            IDLE: begin
                if (OP_VALID) begin
                    case (OP)
                        2'b00: pc_d = pc_inc;
                        2'b01: pc_d = TARGET;
                        2'b10: begin
                            if (STK_FULL) begin
                                fault_d[0] = 1'b1;
                                pc_d       = fault_pc;
                            end else begin
                                din_d   = pc_inc;
                                ce_d    = 1'b1;
                                nrw_d   = 1'b1;
                                tgt_d   = TARGET;
                                state_d = PUSH;
                            end
                        end
                        default: begin
                            if (STK_EMPTY) begin
                                fault_d[1] = 1'b1;
                                pc_d       = fault_pc;
                            end else begin
                                ce_d    = 1'b1;
                                nrw_d   = 1'b0;
                                state_d = POP;
                            end
                        end
                    endcase
                end
            end
            PUSH: begin
                pc_d    = tgt_q;
                state_d = IDLE;
            end
            POP: state_d = LOAD;
            default: begin
                pc_d    = STK_DOUT;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
            din_q   <= '0;
            fault_q <= '0;
            ce_q    <= 1'b0;
            nrw_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            din_q   <= din_d;
            fault_q <= fault_d;
            ce_q    <= ce_d;
            nrw_q   <= nrw_d;
            busy_q  <= busy_d;
        end
    end

    assign PC      = pc_q;
    assign BUSY    = busy_q;
    assign FAULT   = fault_q;
    assign STK_CE  = ce_q;
    assign STK_NRW = nrw_q;
    assign STK_DIN = din_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a small behavioural return-address stack.
module tb_pc_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       OP_VALID;
    logic [1:0] OP;
    logic [7:0] TARGET;
    logic       FAULT_CLR;
    logic [7:0] PC;
    logic       BUSY;
    logic [1:0] FAULT;
    logic       STK_CE;
    logic       STK_NRW;
    logic [7:0] STK_DIN;
    logic [7:0] STK_DOUT;
    logic       STK_FULL;
    logic       STK_EMPTY;

    int checks   = 0;
    int failures = 0;

    // Stack model: depth 4, pop data appears the cycle after the pop edge.
    logic [7:0] mem [0:3];
    int         sp = 0;
    logic       force_full = 1'b0;

    assign STK_FULL  = force_full || (sp == 4);
    assign STK_EMPTY = (sp == 0);

    always @(posedge CLK) begin
        if (STK_CE) begin
            if (STK_NRW) begin
                mem[sp] <= STK_DIN;
                sp      <= sp + 1;
            end else begin
                STK_DOUT <= mem[sp-1];
                sp       <= sp - 1;
            end
        end
    end

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .AW(8),
        .RESET_VECTOR(8'h00),
        .TRAP_VECTOR(8'hF0)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .OP_VALID(OP_VALID),
        .OP(OP),
        .TARGET(TARGET),
        .FAULT_CLR(FAULT_CLR),
        .PC(PC),
        .BUSY(BUSY),
        .FAULT(FAULT),
        .STK_CE(STK_CE),
        .STK_NRW(STK_NRW),
        .STK_DIN(STK_DIN),
        .STK_DOUT(STK_DOUT),
        .STK_FULL(STK_FULL),
        .STK_EMPTY(STK_EMPTY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic [1:0] op, input logic [7:0] tgt);
        OP_VALID = 1'b1;
        OP       = op;
        TARGET   = tgt;
    endtask

    logic [7:0] fpc1, fpc2;

    initial begin
`ifdef PC_SEQ_TRAP_EN
        fpc1 = 8'hF0;
        fpc2 = 8'hF0;
`else
        fpc1 = 8'h21;
        fpc2 = 8'h22;
`endif
        STK_DOUT  = 8'h00;
        nRST      = 1'b0;
        OP_VALID  = 1'b0;
        OP        = 2'b00;
        TARGET    = 8'h00;
        FAULT_CLR = 1'b0;
        #12;
        chk("rst_pc", PC, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_fault", FAULT, 2'b00);
        chk("rst_ce", STK_CE, 1'b0);
        chk("rst_nrw", STK_NRW, 1'b0);
        chk("rst_din", STK_DIN, 8'h00);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // NEXT x3
        req(2'b00, 8'h00);
        tick(); chk("next1_pc", PC, 8'h01); chk("next1_busy", BUSY, 1'b0); chk("next1_ce", STK_CE, 1'b0);
        tick(); chk("next2_pc", PC, 8'h02); chk("next2_ce", STK_CE, 1'b0);
        tick(); chk("next3_pc", PC, 8'h03); chk("next3_busy", BUSY, 1'b0);

        // JUMP and wrap
        req(2'b01, 8'h40);
        tick(); chk("jump_pc", PC, 8'h40);
        req(2'b01, 8'hFF);
        tick(); chk("jumpff_pc", PC, 8'hFF);
        req(2'b00, 8'h00);
        tick(); chk("wrap_pc", PC, 8'h00);

        // Idle hold
        OP_VALID = 1'b0;
        tick(); chk("hold_pc", PC, 8'h00);

        // CALL from 0x10 to 0x80; a NEXT during BUSY must be ignored
        req(2'b01, 8'h10);
        tick();
        req(2'b10, 8'h80);
        tick();
        chk("call_ce", STK_CE, 1'b1);
        chk("call_nrw", STK_NRW, 1'b1);
        chk("call_din", STK_DIN, 8'h11);
        chk("call_busy", BUSY, 1'b1);
        chk("call_pc_hold", PC, 8'h10);
        req(2'b00, 8'h00);
        tick();
        chk("push_ce", STK_CE, 1'b0);
        chk("push_pc", PC, 8'h80);
        chk("push_busy", BUSY, 1'b0);
        chk("push_nrw_hold", STK_NRW, 1'b1);
        OP_VALID = 1'b0;

        // RET: pops 0x11 from the model
        req(2'b11, 8'h00);
        tick();
        chk("ret_ce", STK_CE, 1'b1);
        chk("ret_nrw", STK_NRW, 1'b0);
        chk("ret_busy", BUSY, 1'b1);
        OP_VALID = 1'b0;
        tick();
        chk("pop_ce", STK_CE, 1'b0);
        chk("pop_busy", BUSY, 1'b1);
        chk("pop_pc", PC, 8'h80);
        tick();
        chk("load_pc", PC, 8'h11);
        chk("load_busy", BUSY, 1'b0);

        // Overflow / underflow faults
        req(2'b01, 8'h20);
        tick();
        force_full = 1'b1;
        req(2'b10, 8'h55);
        tick();
        chk("ovf_ce", STK_CE, 1'b0);
        chk("ovf_busy", BUSY, 1'b0);
        chk("ovf_pc", PC, fpc1);
        chk("ovf_fault", FAULT, 2'b01);
        force_full = 1'b0;
        req(2'b11, 8'h00);
        tick();
        chk("unf_ce", STK_CE, 1'b0);
        chk("unf_pc", PC, fpc2);
        chk("unf_fault", FAULT, 2'b11);
        OP_VALID  = 1'b0;
        FAULT_CLR = 1'b1;
        tick();
        chk("clr_fault", FAULT, 2'b00);

        // Set wins over simultaneous clear
        req(2'b11, 8'h00);
        tick();
        chk("setwin_fault", FAULT, 2'b10);
        OP_VALID = 1'b0;
        tick();
        chk("clr2_fault", FAULT, 2'b00);
        FAULT_CLR = 1'b0;

        // Async reset during POP
        req(2'b01, 8'h30);
        tick();
        req(2'b10, 8'h50);
        tick();
        OP_VALID = 1'b0;
        tick();
        chk("call2_pc", PC, 8'h50);
        req(2'b11, 8'h00);
        tick();
        chk("ret2_ce", STK_CE, 1'b1);
        OP_VALID = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_ce", STK_CE, 1'b0);
        chk("arst_pc", PC, 8'h00);
        chk("arst_busy", BUSY, 1'b0);
        #3;
        nRST = 1'b1;
        @(negedge CLK);
        req(2'b00, 8'h00);
        tick();
        chk("post_rst_pc", PC, 8'h01);
        chk("post_rst_busy", BUSY, 1'b0);
        OP_VALID = 1'b0;
        tick();
        chk("post_rst_hold", PC, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
